// File: rtl/calendar_pkg.sv
// Shared types, field limits and month-length helpers for the calendar carry scheduler.
package calendar_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_Y   = 3'd1,
    SET_MON = 3'd2,
    SET_D   = 3'd3,
    SET_H   = 3'd4,
    SET_MIN = 3'd5
  } mode_t;

  typedef struct packed {
    logic s;
    logic min;
    logic h;
    logic d;
    logic mon;
    logic y;
  } field_bits_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [3:0] MON_MAX  = 4'd11;

  // Padded to 16 entries so out-of-range month codes read as 31 days.
  localparam logic [4:0] MONTH_LEN [0:15] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
    5'd31, 5'd31, 5'd31, 5'd31
  };

  function automatic logic is_leap(input logic [6:0] y, input int unsigned leap_mod);
    return (32'(y) % leap_mod) == 32'd0;
  endfunction

  function automatic logic [4:0] month_days(input logic [3:0] mon, input logic leap);
    if (mon == 4'd1 && leap) return 5'd29;
    return MONTH_LEN[mon];
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Days in the month selected by cnt_mon for year count cnt_y (28..31).
import calendar_pkg::*;

module cal_month_len #(
  parameter int unsigned LEAP_MOD = 4
) (
  input  logic [3:0] cnt_mon,
  input  logic [6:0] cnt_y,
  output logic [4:0] dim
);

  assign dim = month_days(cnt_mon, is_leap(cnt_y, LEAP_MOD));

endmodule

// File: rtl/calendar_ctrl.sv
// Per-tick carry/rollover scheduler with a button-driven set mode for the calendar counter chain.
import calendar_pkg::*;

module calendar_ctrl #(
  parameter int unsigned YEAR_MAX = 99,
  parameter int unsigned LEAP_MOD = 4
) (
  input  logic       clk,
  input  logic       set,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cnt_s,
  input  logic [5:0] cnt_min,
  input  logic [4:0] cnt_h,
  input  logic [4:0] cnt_d,
  input  logic [3:0] cnt_mon,
  input  logic [6:0] cnt_y,
  output logic       pulse_s,
  output logic       pulse_min,
  output logic       pulse_h,
  output logic       pulse_d,
  output logic       pulse_mon,
  output logic       pulse_y,
  output logic       clr_s,
  output logic       clr_min,
  output logic       clr_h,
  output logic       clr_d,
  output logic       clr_mon,
  output logic       clr_y,
  output logic [2:0] mode
);

  localparam logic [6:0] Y_LAST = 7'(YEAR_MAX);

  mode_t       state, state_next;
  field_bits_t pulse_q, pulse_n, clr_q, clr_n;
  logic [4:0]  dim, d_last;
  logic        roll_s, roll_min, roll_h, roll_d, roll_mon, roll_y;
  logic        cy_min, cy_h, cy_d, cy_mon, cy_y;

  cal_month_len #(.LEAP_MOD(LEAP_MOD)) u_month_len (
    .cnt_mon (cnt_mon),
    .cnt_y   (cnt_y),
    .dim     (dim)
  );

  assign d_last = dim - 5'd1;

  // A field rolls over at its last value or anything beyond it.
  assign roll_s   = cnt_s   >= SEC_MAX;
  assign roll_min = cnt_min >= MIN_MAX;
  assign roll_h   = cnt_h   >= HOUR_MAX;
  assign roll_d   = cnt_d   >= d_last;
  assign roll_mon = cnt_mon >= MON_MAX;
  assign roll_y   = cnt_y   >= Y_LAST;

  assign cy_min = roll_s;
  assign cy_h   = cy_min & roll_min;
  assign cy_d   = cy_h   & roll_h;
  assign cy_mon = cy_d   & roll_d;
  assign cy_y   = cy_mon & roll_mon;

  always_comb begin
    state_next = state;
    pulse_n    = '0;
    clr_n      = '0;
    unique case (state)
      RUN: begin
        if (tick_1hz) begin
          pulse_n.s   = !roll_s;
          clr_n.s     = roll_s;
          pulse_n.min = cy_min & !roll_min;
          clr_n.min   = cy_min & roll_min;
          pulse_n.h   = cy_h & !roll_h;
          clr_n.h     = cy_h & roll_h;
          pulse_n.d   = cy_d & !roll_d;
          clr_n.d     = cy_d & roll_d;
          pulse_n.mon = cy_mon & !roll_mon;
          clr_n.mon   = cy_mon & roll_mon;
          pulse_n.y   = cy_y & !roll_y;
          clr_n.y     = cy_y & roll_y;
        end
        if (btn_mode) state_next = SET_Y;
      end
      SET_Y: begin
        if (btn_inc) begin
          pulse_n.y = !roll_y;
          clr_n.y   = roll_y;
        end
        if (btn_mode) state_next = SET_MON;
      end
      SET_MON: begin
        if (btn_inc) begin
          pulse_n.mon = !roll_mon;
          clr_n.mon   = roll_mon;
        end
        if (btn_mode) state_next = SET_D;
      end
      SET_D: begin
        if (btn_inc) begin
          pulse_n.d = !roll_d;
          clr_n.d   = roll_d;
        end
        if (btn_mode) state_next = SET_H;
      end
      SET_H: begin
        if (btn_inc) begin
          pulse_n.h = !roll_h;
          clr_n.h   = roll_h;
        end
        if (btn_mode) state_next = SET_MIN;
      end
      SET_MIN: begin
        if (btn_inc) begin
          pulse_n.min = !roll_min;
          clr_n.min   = roll_min;
        end
        if (btn_mode) begin
          state_next = RUN;
          clr_n.s    = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
    // Day clamp after a month/year edit; overrides any day increment.
    if (state != RUN && cnt_d > d_last) begin
      clr_n.d   = 1'b1;
      pulse_n.d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (set) begin
      state   <= RUN;
      pulse_q <= '0;
      clr_q   <= '0;
    end else begin
      state   <= state_next;
      pulse_q <= pulse_n;
      clr_q   <= clr_n;
    end
  end

  assign {pulse_s, pulse_min, pulse_h, pulse_d, pulse_mon, pulse_y} = pulse_q;
  assign {clr_s, clr_min, clr_h, clr_d, clr_mon, clr_y}             = clr_q;
  assign mode = state;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Self-checking bench for calendar_ctrl: vector table, set-mode sequences and randomized ticks vs a date model.
module tb_calendar_ctrl;

  localparam int YEAR_MAX = 99;

  logic       clk = 1'b0;
  logic       set, tick_1hz, btn_mode, btn_inc;
  logic [5:0] cnt_s, cnt_min;
  logic [4:0] cnt_h, cnt_d;
  logic [3:0] cnt_mon;
  logic [6:0] cnt_y;
  logic       pulse_s, pulse_min, pulse_h, pulse_d, pulse_mon, pulse_y;
  logic       clr_s, clr_min, clr_h, clr_d, clr_mon, clr_y;
  logic [2:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  calendar_ctrl #(.YEAR_MAX(YEAR_MAX), .LEAP_MOD(4)) dut (
    .clk(clk), .set(set), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cnt_s(cnt_s), .cnt_min(cnt_min), .cnt_h(cnt_h), .cnt_d(cnt_d),
    .cnt_mon(cnt_mon), .cnt_y(cnt_y),
    .pulse_s(pulse_s), .pulse_min(pulse_min), .pulse_h(pulse_h), .pulse_d(pulse_d),
    .pulse_mon(pulse_mon), .pulse_y(pulse_y),
    .clr_s(clr_s), .clr_min(clr_min), .clr_h(clr_h), .clr_d(clr_d),
    .clr_mon(clr_mon), .clr_y(clr_y), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s, mi, h, d, mo, y;
    logic [11:0] exp;   // {pulse s,min,h,d,mon,y, clr s,min,h,d,mon,y}
  } vec_t;

  function automatic logic [11:0] outs();
    return {pulse_s, pulse_min, pulse_h, pulse_d, pulse_mon, pulse_y,
            clr_s, clr_min, clr_h, clr_d, clr_mon, clr_y};
  endfunction

  // Calendar rules stated directly in terms of the real year 2000+y.
  function automatic int days_in_month(int mo, int y);
    int yr = 2000 + y;
    if (mo == 1) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 3 || mo == 5 || mo == 8 || mo == 10) return 30;
    return 31;
  endfunction

  // Advance the date by one second; report which fields moved up and which wrapped to 0.
  function automatic logic [11:0] model_tick(int s, int mi, int h, int d, int mo, int y);
    int          cur [6];
    int          last[6];
    logic [11:0] e = '0;
    bit          carry = 1;
    cur  = '{s, mi, h, d, mo, y};
    last = '{59, 59, 23, days_in_month(mo, y) - 1, 11, YEAR_MAX};
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (cur[i] >= last[i]) e[5 - i] = 1'b1;
        else begin
          e[11 - i] = 1'b1;
          carry = 0;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_mode(input string name, input logic [2:0] exp);
    n_checks++;
    if (mode !== exp) begin
      n_fail++;
      $display("FAIL %s: mode got %0d expected %0d", name, mode, exp);
    end
  endtask

  task automatic counts(input int s, input int mi, input int h, input int d, input int mo, input int y);
    cnt_s = 6'(s); cnt_min = 6'(mi); cnt_h = 5'(h); cnt_d = 5'(d); cnt_mon = 4'(mo); cnt_y = 7'(y);
  endtask

  task automatic step(input logic tk, input logic bm, input logic bi);
    tick_1hz = tk; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    set = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    counts(0, 0, 0, 0, 0, 0);
    vecs[0] = '{0,  0,  0,  0,  0,  0,  12'b100000_000000};
    vecs[1] = '{59, 59, 23, 30, 11, 99, 12'b000000_111111};
    vecs[2] = '{59, 59, 23, 27, 1,  1,  12'b000010_111100};
    vecs[3] = '{59, 59, 23, 27, 1,  4,  12'b000100_111000};
    vecs[4] = '{59, 59, 23, 28, 1,  4,  12'b000010_111100};
    vecs[5] = '{59, 59, 23, 29, 3,  7,  12'b000010_111100};
    vecs[6] = '{59, 59, 23, 29, 0,  7,  12'b000100_111000};
    vecs[7] = '{59, 59, 10, 5,  6,  20, 12'b001000_110000};
    vecs[8] = '{63, 5,  0,  0,  0,  0,  12'b010000_100000};
    vecs[9] = '{59, 59, 23, 30, 11, 5,  12'b000001_111110};

    step(1'b1, 1'b0, 1'b0);
    check("reset outputs", outs(), 12'b0);
    check_mode("reset mode", 3'd0);
    set = 1'b0;

    foreach (vecs[i]) begin
      counts(vecs[i].s, vecs[i].mi, vecs[i].h, vecs[i].d, vecs[i].mo, vecs[i].y);
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("vec%0d tick", i), outs(), vecs[i].exp);
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d idle", i), outs(), 12'b0);
    end

    // RUN: btn_inc ignored; tick with btn_mode still processed.
    counts(10, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1);
    check("run inc ignored", outs(), 12'b0);
    step(1'b1, 1'b1, 1'b0);
    check("run tick+mode", outs(), 12'b100000_000000);
    check_mode("run tick+mode", 3'd1);

    // SET_Y wrap, then SET_MON wrap, frozen tick and day clamp.
    counts(10, 0, 0, 0, 0, 99);
    step(1'b0, 1'b0, 1'b1);
    check("set_y wrap", outs(), 12'b000000_000001);
    step(1'b0, 1'b1, 1'b0);
    check_mode("to set_mon", 3'd2);
    counts(10, 0, 0, 0, 11, 1);
    step(1'b0, 1'b0, 1'b1);
    check("set_mon wrap", outs(), 12'b000000_000010);
    step(1'b1, 1'b0, 1'b0);
    check("tick frozen", outs(), 12'b0);
    counts(10, 0, 0, 30, 1, 1);
    step(1'b0, 1'b0, 1'b0);
    check("clamp feb y1", outs(), 12'b000000_000100);
    counts(10, 0, 0, 28, 1, 4);
    step(1'b0, 1'b0, 1'b0);
    check("no clamp feb29 leap", outs(), 12'b0);
    counts(10, 0, 0, 28, 1, 5);
    step(1'b0, 1'b0, 1'b0);
    check("clamp feb29 nonleap", outs(), 12'b000000_000100);

    // SET_D: wrap at end of April, plain increment, then reset mid-state.
    counts(10, 0, 0, 29, 3, 5);
    step(1'b0, 1'b1, 1'b0);
    check_mode("to set_d", 3'd3);
    step(1'b0, 1'b0, 1'b1);
    check("set_d wrap apr", outs(), 12'b000000_000100);
    counts(10, 0, 0, 10, 3, 5);
    step(1'b0, 1'b0, 1'b1);
    check("set_d inc", outs(), 12'b000100_000000);
    set = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    set = 1'b0;
    check("reset mid set_d", outs(), 12'b0);
    check_mode("reset mid set_d", 3'd0);

    // Full mode cycle; inc+mode together in SET_H; clr_s on return to RUN.
    counts(10, 0, 23, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) begin
        step(1'b0, 1'b1, 1'b1);
        check("set_h inc+mode", outs(), 12'b000000_001000);
      end else step(1'b0, 1'b1, 1'b0);
      if (k == 6) check("leave set_min", outs(), 12'b000000_100000);
      check_mode($sformatf("mode cycle %0d", k), 3'(k % 6));
    end
    step(1'b0, 1'b0, 1'b0);
    check("after return idle", outs(), 12'b0);

    // Randomized ticks in RUN against the date model.
    for (int n = 0; n < 300; n++) begin
      int s, mi, h, d, mo, y;
      logic tk;
      bit near = ($urandom_range(0, 1) == 1);
      s  = near ? 59 : $urandom_range(0, 59);
      mi = (near && $urandom_range(0, 3) != 0) ? 59 : $urandom_range(0, 59);
      h  = (near && $urandom_range(0, 3) != 0) ? 23 : $urandom_range(0, 23);
      mo = $urandom_range(0, 11);
      y  = (near && $urandom_range(0, 3) == 0) ? YEAR_MAX : $urandom_range(0, YEAR_MAX);
      d  = near ? days_in_month(mo, y) - 1 - $urandom_range(0, 1) : $urandom_range(0, 30);
      if (near && $urandom_range(0, 1) == 1) mo = 11;
      tk = ($urandom_range(0, 3) != 0);
      counts(s, mi, h, d, mo, y);
      step(tk, 1'b0, 1'b0);
      check($sformatf("rand%0d %0d:%0d:%0d d%0d m%0d y%0d", n, h, mi, s, d, mo, y),
            outs(), tk ? model_tick(s, mi, h, d, mo, y) : 12'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
